// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, default bit timing and frame shape.
// The receiver side imports the same constants so both ends agree on the baud divider.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // 12 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 104;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO in front of the UART serialiser.
// Occupancy counter drives full/empty; pointers wrap naturally because DEPTH is a power of two.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake into a FIFO, then a START/DATA/STOP
// serialiser timed by a cycle divider. Line and busy flag are both registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
  logic          avail_reg;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic          bit_done;

  assign o_ready  = !fifo_full && !i_rst;
  assign push     = i_valid && o_ready;
  assign bit_done = (cnt_reg == CNT_LAST);
  assign o_tx     = tx_reg;
  assign o_busy   = busy_reg;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (i_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // avail_reg lags the FIFO by one cycle; pops are at least a frame apart, so the lag is harmless.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (avail_reg) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          cnt_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == BIT_LAST) state_next = STOP;
          else                     bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          if (avail_reg) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE) || !fifo_empty;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      avail_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      avail_reg <= !fifo_empty;
    end
  end

endmodule
